// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_bist_pkg
// Description : Shared types and March C- element tables for ram_march_bist.
//               Tables are indexed by element number; bit e describes Me.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_CMP  = 3'd4,
    S_WRB  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [2:0] c_M0 = 3'd0;
  localparam logic [2:0] c_M1 = 3'd1;
  localparam logic [2:0] c_M2 = 3'd2;
  localparam logic [2:0] c_M3 = 3'd3;
  localparam logic [2:0] c_M4 = 3'd4;
  localparam logic [2:0] c_M5 = 3'd5;

  // Element walks addresses downward (M3, M4, M5)
  localparam logic [7:0] c_ELEM_DOWN    = 8'b0011_1000;
  // Element expects all-ones on read (M2, M4); otherwise all-zeros
  localparam logic [7:0] c_ELEM_RD_ONES = 8'b0001_0100;
  // Element writes all-ones (M1, M3); otherwise all-zeros
  localparam logic [7:0] c_ELEM_WR_ONES = 8'b0000_1010;
  // Element performs a read (M1..M5)
  localparam logic [7:0] c_ELEM_HAS_RD  = 8'b0011_1110;
  // Element performs a write (M0..M4)
  localparam logic [7:0] c_ELEM_HAS_WR  = 8'b0001_1111;

  function automatic logic elem_flag(input logic [7:0] tbl, input logic [2:0] elem);
    return tbl[elem];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : bist_addr_gen
// Description : Up/down address counter for the March walker. Load selects
//               the first address of an element (0 or N-1); o_last flags the
//               final address in the current direction.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_addr_gen #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_load_hi,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;

  // Address register: load has priority over stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_hi ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == {ADDR_W{1'b0}}) : (r_addr == {ADDR_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : ram_march_bist
// Description : March C- BIST initiator for a small synchronous RAM. Owns the
//               RAM port while busy, compares read data, reports pass/fail.
// Config      : BIST_ERR_LOG_EN - adds err_addr/err_data/err_elem capturing
//               the first mismatch of a run.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BIST_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [2:0]        err_elem
`endif
);

  localparam int c_WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_elem;
  logic                r_fail;
  logic                r_done;
  logic                r_pass;
  logic [c_WAIT_W-1:0] r_wait_cnt;

  logic                w_ag_load;
  logic                w_ag_load_hi;
  logic                w_ag_step;
  logic                w_down;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_last;
  logic                w_adv;
  logic                w_elem_inc;
  logic                w_wait_inc;
  logic                w_has_wr;
  logic                w_start_ok;
  logic                w_mismatch;
  logic [DATA_W-1:0]   w_exp;

  assign w_down       = elem_flag(c_ELEM_DOWN, r_elem);
  assign w_has_wr     = elem_flag(c_ELEM_HAS_WR, r_elem);
  assign w_exp        = elem_flag(c_ELEM_RD_ONES, r_elem) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  assign w_mismatch   = (mem_rdata != w_exp);
  assign w_start_ok   = (r_state == S_IDLE) && start;
  // The first address of the next element depends on that element's direction
  assign w_ag_load_hi = (r_state != S_IDLE) && elem_flag(c_ELEM_DOWN, r_elem + 3'd1);

  bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_ag_load),
    .i_load_hi (w_ag_load_hi),
    .i_step    (w_ag_step),
    .i_down    (w_down),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and address/element sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_ag_load   = 1'b0;
    w_ag_step   = 1'b0;
    w_elem_inc  = 1'b0;
    w_adv       = 1'b0;
    w_wait_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WR;
          w_ag_load   = 1'b1;
        end
      end
      S_WR:   w_adv = 1'b1;
      S_RD:   w_state_nxt = (RD_LAT == 1) ? S_CMP : S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == c_WAIT_W'(RD_LAT - 2)) begin
          w_state_nxt = S_CMP;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_CMP: begin
        if (w_has_wr) begin
          w_state_nxt = S_WRB;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_WRB:  w_adv = 1'b1;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Finishing work on one address: step within the element or move on
    if (w_adv) begin
      if (!w_last) begin
        w_ag_step   = 1'b1;
        w_state_nxt = (r_elem == c_M0) ? S_WR : S_RD;
      end else if (r_elem == c_M5) begin
        w_state_nxt = S_DONE;
      end else begin
        w_elem_inc  = 1'b1;
        w_ag_load   = 1'b1;
        w_state_nxt = S_RD;
      end
    end
  end

  // Element index, sticky fail flag, read-latency counter and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem     <= c_M0;
      r_fail     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_elem <= c_M0;
        r_fail <= 1'b0;
        r_pass <= 1'b0;
      end else begin
        if (w_elem_inc) begin
          r_elem <= r_elem + 3'd1;
        end
        if ((r_state == S_CMP) && w_mismatch) begin
          r_fail <= 1'b1;
        end
        if (r_state == S_DONE) begin
          r_pass <= ~r_fail;
        end
      end
      if (r_state == S_RD) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

`ifdef BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_data;
  logic [2:0]        r_err_elem;

  // Capture only the first mismatch of a run; cleared when a run starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_addr <= '0;
      r_err_data <= '0;
      r_err_elem <= '0;
    end else if (w_start_ok) begin
      r_err_addr <= '0;
      r_err_data <= '0;
      r_err_elem <= '0;
    end else if ((r_state == S_CMP) && w_mismatch && !r_fail) begin
      r_err_addr <= w_addr;
      r_err_data <= mem_rdata;
      r_err_elem <= r_elem;
    end
  end

  assign err_addr = r_err_addr;
  assign err_data = r_err_data;
  assign err_elem = r_err_elem;
`endif

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign mem_we    = (r_state == S_WR) || (r_state == S_WRB);
  assign mem_addr  = busy ? w_addr : {ADDR_W{1'b0}};
  assign mem_wdata = ((r_state == S_WRB) && elem_flag(c_ELEM_WR_ONES, r_elem))
                     ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_march_bist
// Description : Scoreboard bench for ram_march_bist. Two DUTs (RD_LAT 1 and 2)
//               with behavioural RAMs carrying an optional stuck-at bit. The
//               March C- reference model runs on a plain array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_march_bist;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fault injected into both RAM models (only one DUT runs at a time)
  bit f_en  = 1'b0;
  int f_addr = 0;
  int f_bit  = 0;
  bit f_val  = 1'b0;

  logic       start, busy, done, pass, mem_we;
  logic [1:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;
  logic       start2, busy2, done2, pass2, mem_we2;
  logic [1:0] mem_addr2;
  logic [3:0] mem_wdata2, mem_rdata2;
`ifdef BIST_ERR_LOG_EN
  logic [1:0] err_addr, err_addr2;
  logic [3:0] err_data, err_data2;
  logic [2:0] err_elem, err_elem2;
`endif

  ram_march_bist #(.ADDR_W(2), .DATA_W(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BIST_ERR_LOG_EN
    , .err_addr(err_addr), .err_data(err_data), .err_elem(err_elem)
`endif
  );

  ram_march_bist #(.ADDR_W(2), .DATA_W(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
`ifdef BIST_ERR_LOG_EN
    , .err_addr(err_addr2), .err_data(err_data2), .err_elem(err_elem2)
`endif
  );

  function automatic logic [3:0] rd_fault(input logic [3:0] d, input int a);
    logic [3:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // RAM models: write on clock edge, read data delayed by RD_LAT register stages
  logic [3:0] mem1 [4];
  logic [3:0] mem2 [4];
  logic [3:0] rp1, rp2a, rp2b;
  always @(posedge clk) begin
    if (mem_we) mem1[mem_addr] <= mem_wdata;
    rp1 <= rd_fault(mem1[mem_addr], int'(mem_addr));
    if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
    rp2a <= rd_fault(mem2[mem_addr2], int'(mem_addr2));
    rp2b <= rp2a;
  end
  assign mem_rdata  = rp1;
  assign mem_rdata2 = rp2b;

  typedef struct {
    bit         pass;
    logic [1:0] ea;
    logic [3:0] ed;
    logic [2:0] ee;
    int         blen;
    int         cycles;
  } exp_t;

  typedef struct {
    bit         we;
    int         addr;
    logic [3:0] wd;
    int         kind; // 0: we only, 1: we+addr, 2: we+addr+wdata
  } tr_t;

  exp_t expq[$];
  exp_t exp2q[$];
  tr_t  trq[$];

  // March C- as a table: direction, read value (-1 none), write value (-1 none)
  function automatic exp_t model(input int lat);
    exp_t r;
    logic [3:0] m [4];
    logic [3:0] v;
    int dir [6] = '{0, 0, 0, 1, 1, 1};
    int rdv [6] = '{-1, 0, 15, 0, 15, 0};
    int wrv [6] = '{0, 15, 0, 15, 0, -1};
    int a;
    r.pass = 1'b1; r.ea = '0; r.ed = '0; r.ee = '0; r.blen = 0; r.cycles = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = (dir[e] != 0) ? (N - 1 - k) : k;
        if (rdv[e] >= 0) begin
          v = rd_fault(m[a], a);
          r.blen += 1 + lat;
          if (v != 4'(rdv[e]) && r.pass) begin
            r.pass = 1'b0; r.ea = 2'(a); r.ed = v; r.ee = 3'(e);
          end
        end
        if (wrv[e] >= 0) begin
          m[a] = 4'(wrv[e]);
          r.blen += 1;
        end
      end
    end
    return r;
  endfunction

  task automatic push_trace(input int lat);
    int dir [6] = '{0, 0, 0, 1, 1, 1};
    int rdv [6] = '{-1, 0, 15, 0, 15, 0};
    int wrv [6] = '{0, 15, 0, 15, 0, -1};
    int a;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = (dir[e] != 0) ? (N - 1 - k) : k;
        if (rdv[e] >= 0) begin
          trq.push_back('{1'b0, a, 4'h0, 1});
          for (int j = 0; j < lat; j++) trq.push_back('{1'b0, 0, 4'h0, 0});
        end
        if (wrv[e] >= 0) trq.push_back('{1'b1, a, 4'(wrv[e]), 2});
      end
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Port-activity monitor for the RD_LAT=1 DUT
  initial begin : mon_trace
    tr_t t;
    bit  ok;
    forever begin
      @(negedge clk);
      if (busy) begin
        total++;
        if (trq.size() == 0) begin
          bad++;
          $display("FAIL trace_overrun: got busy=1 expected idle at cycle %0d", cyc);
        end else begin
          t  = trq.pop_front();
          ok = (mem_we == t.we) && (t.kind < 1 || int'(mem_addr) == t.addr) &&
               (t.kind < 2 || mem_wdata == t.wd);
          if (!ok) begin
            bad++;
            $display("FAIL trace: got we=%0d addr=%0d wdata=%h expected we=%0d addr=%0d wdata=%h (kind %0d)",
                     mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wd, t.kind);
          end
        end
      end
    end
  end

  // Run-result monitor for the RD_LAT=1 DUT
  initial begin : mon_run1
    bit   pb = 1'b0;
    int   bl = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !pb) bl = 0;
      if (busy) bl++;
      pb = busy;
      if (done) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected no run pending at cycle %0d", cyc);
        end else begin
          e = expq.pop_front();
          chk("done_cycle", cyc, e.cycles);
          chk("busy_len", bl, e.blen);
          chk("pass", pass, e.pass);
          chk("busy_at_done", busy, 0);
`ifdef BIST_ERR_LOG_EN
          chk("err_addr", err_addr, e.ea);
          chk("err_data", err_data, e.ed);
          chk("err_elem", err_elem, e.ee);
`endif
        end
      end
    end
  end

  // Run-result monitor for the RD_LAT=2 DUT
  initial begin : mon_run2
    bit   pb = 1'b0;
    int   bl = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy2 && !pb) bl = 0;
      if (busy2) bl++;
      pb = busy2;
      if (done2) begin
        if (exp2q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done2: got done=1 expected no run pending at cycle %0d", cyc);
        end else begin
          e = exp2q.pop_front();
          chk("done_cycle2", cyc, e.cycles);
          chk("busy_len2", bl, e.blen);
          chk("pass2", pass2, e.pass);
`ifdef BIST_ERR_LOG_EN
          chk("err_addr2", err_addr2, e.ea);
          chk("err_data2", err_data2, e.ed);
          chk("err_elem2", err_elem2, e.ee);
`endif
        end
      end
    end
  end

  // Called at a negedge; issues start and records the expected run
  task automatic start_run(input bit rep);
    exp_t e;
    e = model(1);
    start = 1'b1;
    @(posedge clk); #1;
    e.cycles = cyc + e.blen + 1;
    expq.push_back(e);
    push_trace(1);
    @(negedge clk);
    start = 1'b0;
    if (rep) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic start_run2();
    exp_t e;
    e = model(2);
    start2 = 1'b1;
    @(posedge clk); #1;
    e.cycles = cyc + e.blen + 1;
    exp2q.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Returns at the negedge where done is seen
  task automatic wait_done(input bit second);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (second ? done2 : done) return;
    end
    total++; bad++;
    $display("FAIL done_timeout: got no done expected done within 300 cycles (dut%0d)", second ? 2 : 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    start  = 1'b0;
    start2 = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
`ifdef BIST_ERR_LOG_EN
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_data", err_data, 0);
    chk("rst_err_elem", err_elem, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // fault-free run with default latency
    @(negedge clk);
    start_run(1'b0);
    wait_done(1'b0);
    chk("t1_pass", pass, 1);

    // bit0 stuck-at-1 at address 2; start issued in the done cycle
    f_en = 1'b1; f_addr = 2; f_bit = 0; f_val = 1'b1;
    start_run(1'b0);
    wait_done(1'b0);
    chk("t2_pass", pass, 0);
`ifdef BIST_ERR_LOG_EN
    chk("t2_err_addr", err_addr, 2);
    chk("t2_err_data", err_data, 1);
    chk("t2_err_elem", err_elem, 1);
`endif

    // start re-pulsed while busy is ignored
    f_en = 1'b0;
    repeat (3) @(negedge clk);
    start_run(1'b1);
    wait_done(1'b0);

    // asynchronous reset mid-run
    @(negedge clk);
    start_run(1'b0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_we", mem_we, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    expq.delete();
    trq.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    start_run(1'b0);
    wait_done(1'b0);
    chk("t5_pass_after", pass, 1);

    // randomized faults, gaps, back-to-back starts and re-pulses
    for (int it = 0; it < 10; it++) begin
      f_en   = 1'($urandom_range(0, 1));
      f_addr = int'($urandom_range(0, 3));
      f_bit  = int'($urandom_range(0, 3));
      f_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_run(1'($urandom_range(0, 1)));
      wait_done(1'b0);
    end

    // read latency of 2: fault-free, then a random fault
    f_en = 1'b0;
    repeat (2) @(negedge clk);
    start_run2();
    wait_done(1'b1);
    chk("t6_pass", pass2, 1);
    f_en = 1'b1; f_addr = int'($urandom_range(0, 3)); f_bit = int'($urandom_range(0, 3));
    f_val = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    start_run2();
    wait_done(1'b1);

    repeat (4) @(negedge clk);
    chk("pending_runs", expq.size() + exp2q.size(), 0);
    chk("pending_trace", trq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
